// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX engine and the future RX block.
// Defining UART_TX_PARITY_EN adds the even-parity state and parity helper.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } uart_tx_state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Clearing realigns the bit grid to the cycle after clr.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wrapping at LAST keeps every bit exactly CLKS_PER_BIT cycles long.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit engine: pops bytes from the TX FIFO and sends them 8N1 on tx.
// Defining UART_TX_PARITY_EN switches frames to 8E1 (even parity bit before stop).
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            TxEn,
  input  logic                            FfEmpty,
  input  logic [uart_pkg::UART_DATA_BITS-1:0] FfData,
  output logic                            FfRdEn,
  output logic                            tx,
  output logic                            busy,
  output logic                            tx_done
);

  import uart_pkg::*;

  localparam int             IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]          r_bitIdx;
  logic                      r_tx;
  logic                      r_rdEn;
  logic                      r_busy;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  logic w_tick;
  logic w_clr;

  assign w_clr = (r_state == ST_LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .tick(w_tick)
  );

  // FETCH/LOAD give the FIFO one cycle to present registered data before the start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_tx     <= 1'b1;
      r_rdEn   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_rdEn <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (TxEn && !FfEmpty) begin
            r_state <= ST_FETCH;
            r_rdEn  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_shift  <= FfData;
          r_bitIdx <= '0;
`ifdef UART_TX_PARITY_EN
          r_parity <= even_parity(FfData);
`endif
          r_tx     <= 1'b0;
          r_state  <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift  <= r_shift >> 1;
            r_bitIdx <= r_bitIdx + IDX_W'(1);
            if (r_bitIdx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_tx <= 1'b1;
            if (TxEn && !FfEmpty) begin
              r_state <= ST_FETCH;
              r_rdEn  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign FfRdEn  = r_rdEn;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = (r_state == ST_STOP) && w_tick;

endmodule
